voice_allocator: RTL and testbench
==================================

# voice_allocator

Parametrised voice allocator and mixer between the song reader and NUM_VOICES external `note_player` instances. Each incoming note goes to a free voice, or, with stealing compiled in, to the oldest busy voice. The block gathers one sample per voice per codec frame and emits a single scaled, saturated mix with a one-cycle ready strobe. It is the generalised successor of the three-voice note distributor.

## Interface

Parameters:
- NUM_VOICES, 3: number of voices, range 2..8
- SAMPLE_W, 16: signed sample width
- NOTE_W, 6: note code width
- DUR_W, 6: duration width
- MIX_SHIFT, 2: arithmetic right shift applied to the mix sum
- AGE_W, 8: width of the per-voice age counter, which saturates

Ports:
- clk  in  1  single clock; all logic on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- load_new_note  in  1  one-cycle request to start a note
- note_to_load  in  NOTE_W  note code, sampled with load_new_note
- duration_to_load  in  DUR_W  duration, sampled with load_new_note
- voice_playing  in  NUM_VOICES  busy flag from each note_player
- voice_sample  in  NUM_VOICES*SAMPLE_W  flattened samples; voice i occupies bits [i*SAMPLE_W +: SAMPLE_W]
- voice_sample_ready  in  NUM_VOICES  per-voice sample strobe
- voice_load  out  NUM_VOICES  one-hot load pulse
- voice_note  out  NOTE_W  registered note, valid while voice_load is high
- voice_duration  out  DUR_W  registered duration, valid while voice_load is high
- sample_out  out  SAMPLE_W  mixed sample, held between updates
- new_sample_ready  out  1  one-cycle strobe when sample_out updates
- active_count  out  $clog2(NUM_VOICES+1)  population count of (voice_playing | pending)
- note_dropped  out  1  one-cycle pulse when a request is discarded

## Operation

Allocation:
- pending[i] is set when voice_load[i] fires. It clears on the first cycle voice_playing[i] is high. This stops back-to-back requests from landing on the same voice before it reports busy.
- A voice is free when both voice_playing[i] and pending[i] are 0.
- On load_new_note, select the lowest-index free voice. Register the one-hot result into voice_load and latch note and duration.
- age[i] clears to 0 when voice i is loaded. Every other voice's age increments by 1 on each accepted load, saturating at all-ones.
- No free voice: behaviour is set by the configuration macro (see Configuration).

Mixing FSM, states COLLECT and EMIT:
- COLLECT: on voice_sample_ready[i], latch voice_sample[i] and set got[i]. When got becomes all-ones, move to EMIT.
- EMIT (one cycle):
  - Sum all latched samples, each sign-extended to SAMPLE_W+$clog2(NUM_VOICES) bits.
  - Apply an arithmetic shift right by MIX_SHIFT.
  - Saturate to the signed SAMPLE_W range.
  - Register the result into sample_out and pulse new_sample_ready.
  - Clear got and return to COLLECT.
- A voice_sample_ready that arrives during EMIT is latched and counts toward the next frame.
- A repeat strobe from a voice already marked in got overwrites that voice's latched sample. got is unchanged.

## Timing

- Reset values: voice_load, new_sample_ready and note_dropped are 0; sample_out, voice_note and voice_duration are 0; active_count is 0; pending, age and got are cleared; FSM is in COLLECT.
- Load latency: load_new_note at cycle t gives voice_load at t+1, with voice_note and voice_duration valid in the same cycle.
- A new request may arrive every cycle. Consecutive accepted requests always target distinct voices.
- note_dropped pulses at t+1 for a request at t.
- Mix latency: the last missing voice_sample_ready at cycle t gives new_sample_ready and sample_out at t+2 (one cycle to latch, EMIT at t+1, registered output at t+2).
- Reset asserted mid-operation clears everything immediately. A load pulse in flight is lost.

## Configuration

VOICE_STEAL_EN:
- Defined: with all voices busy, select the voice with the largest age, lowest index on ties. Load it like a free voice; note_dropped stays 0.
- Undefined: with all voices busy, pulse note_dropped. voice_load stays 0 and ages do not change. The age counters and stealing logic are not compiled.

## Structure

- Shared package `voice_pkg`: default widths, the FSM state encoding, and a saturate function parameterised on width.
- One sub-module, `voice_select`: combinational. Takes the free mask and ages; returns a one-hot grant and a none-free flag. It holds both the priority and the oldest-voice paths.

## Test plan

- NUM_VOICES=3, all voices idle; three requests on consecutive cycles → voice_load 001, 010, 100 on successive cycles, each with its own note and duration.
- NUM_VOICES=3, all voices playing, steal enabled; loads to voices 0, 1, 2 in order, then a fourth request → voice_load=001 (voice 0 is oldest).
- Same setup with steal disabled → note_dropped pulses for one cycle; voice_load stays 0.
- Samples 0x7FFF on all three voices, MIX_SHIFT=0 → sample_out=0x7FFF (saturated). Samples 0x8000 on all three → 0x8000.
- Samples 400, -200, 100 with MIX_SHIFT=2; ready strobes staggered over 5 cycles → one new_sample_ready, two cycles after the last strobe, with sample_out=75.
- reset_n pulled low while got=011 and a load is pending → all outputs 0 immediately; the next frame needs all three voice strobes before emitting.

Source files
------------

// File: rtl/voice_pkg.sv
// Shared defaults, mixer FSM encoding and the saturation helper for voice_allocator.
// Optional voice stealing is selected with the VOICE_STEAL_EN macro.
package voice_pkg;

    localparam int DEF_NUM_VOICES = 3;
    localparam int DEF_SAMPLE_W   = 16;
    localparam int DEF_NOTE_W     = 6;
    localparam int DEF_DUR_W      = 6;
    localparam int DEF_MIX_SHIFT  = 2;
    localparam int DEF_AGE_W      = 8;

    typedef enum logic {
        COLLECT = 1'b0,
        EMIT    = 1'b1
    } mix_state_e;

    // Clamp a signed value into the signed range of a 'width'-bit word; caller truncates.
    function automatic logic signed [31:0] saturate(input logic signed [31:0] value,
                                                    input int width);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (width - 1)) - 32'sd1;
        lo = -hi - 32'sd1;
        if (value > hi) begin
            return hi;
        end else if (value < lo) begin
            return lo;
        end else begin
            return value;
        end
    endfunction

endpackage

// File: rtl/voice_select.sv
// Combinational voice picker: lowest-index free voice, or with VOICE_STEAL_EN the
// oldest voice (lowest index on ties) when nothing is free.
module voice_select
    import voice_pkg::*;
#(
    parameter int NUM_VOICES = DEF_NUM_VOICES,
    parameter int AGE_W      = DEF_AGE_W
) (
    input  logic [NUM_VOICES-1:0]       free,
`ifdef VOICE_STEAL_EN
    input  logic [NUM_VOICES*AGE_W-1:0] ages,
`endif
    output logic [NUM_VOICES-1:0]       grant,
    output logic                        none_free
);

    logic [NUM_VOICES-1:0] grant_free;
    logic                  found;

    always_comb begin
        grant_free = '0;
        found      = 1'b0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (free[i] && !found) begin
                grant_free[i] = 1'b1;
                found         = 1'b1;
            end
        end
    end

    assign none_free = ~|free;

`ifdef VOICE_STEAL_EN
    localparam int IDX_W = $clog2(NUM_VOICES);

    logic [NUM_VOICES-1:0] grant_oldest;
    logic [AGE_W-1:0]      best_age;
    logic [IDX_W-1:0]      best_idx;

    // Strict greater-than keeps the earlier (lower) index on equal ages.
    always_comb begin
        best_age     = ages[AGE_W-1:0];
        best_idx     = '0;
        grant_oldest = '0;
        for (int i = 1; i < NUM_VOICES; i++) begin
            if (ages[i*AGE_W +: AGE_W] > best_age) begin
                best_age = ages[i*AGE_W +: AGE_W];
                best_idx = IDX_W'(i);
            end
        end
        for (int i = 0; i < NUM_VOICES; i++) begin
            grant_oldest[i] = (best_idx == IDX_W'(i));
        end
    end

    assign grant = none_free ? grant_oldest : grant_free;
`else
    assign grant = grant_free;
`endif

endmodule

// File: rtl/voice_allocator.sv
// Voice allocator and frame mixer for NUM_VOICES note players.
// Define VOICE_STEAL_EN to steal the oldest voice instead of dropping when all are busy.
module voice_allocator
    import voice_pkg::*;
#(
    parameter int NUM_VOICES = DEF_NUM_VOICES,
    parameter int SAMPLE_W   = DEF_SAMPLE_W,
    parameter int NOTE_W     = DEF_NOTE_W,
    parameter int DUR_W      = DEF_DUR_W,
    parameter int MIX_SHIFT  = DEF_MIX_SHIFT,
    parameter int AGE_W      = DEF_AGE_W
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           load_new_note,
    input  logic [NOTE_W-1:0]              note_to_load,
    input  logic [DUR_W-1:0]               duration_to_load,
    input  logic [NUM_VOICES-1:0]          voice_playing,
    input  logic [NUM_VOICES*SAMPLE_W-1:0] voice_sample,
    input  logic [NUM_VOICES-1:0]          voice_sample_ready,
    output logic [NUM_VOICES-1:0]          voice_load,
    output logic [NOTE_W-1:0]              voice_note,
    output logic [DUR_W-1:0]               voice_duration,
    output logic [SAMPLE_W-1:0]            sample_out,
    output logic                           new_sample_ready,
    output logic [$clog2(NUM_VOICES+1)-1:0] active_count,
    output logic                           note_dropped,
    output mix_state_e                     mix_state
);

    // Handshake: load_new_note is a single-cycle request with no backpressure; it is
    // either granted (voice_load one-hot at t+1) or discarded (note_dropped at t+1).
    // voice_sample_ready strobes are always accepted; new_sample_ready is a pulse.

    localparam int CNT_W = $clog2(NUM_VOICES + 1);
    localparam int SUM_W = SAMPLE_W + $clog2(NUM_VOICES);

    logic [NUM_VOICES-1:0] pending;
    logic [NUM_VOICES-1:0] free;
    logic [NUM_VOICES-1:0] grant;
    logic                  none_free;
    logic                  accept;

    // pending covers the gap between a grant and the player raising voice_playing.
    assign free = ~(voice_playing | pending);

`ifdef VOICE_STEAL_EN
    logic [AGE_W-1:0]            age [NUM_VOICES];
    logic [NUM_VOICES*AGE_W-1:0] ages_flat;

    always_comb begin
        ages_flat = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            ages_flat[i*AGE_W +: AGE_W] = age[i];
        end
    end

    voice_select #(
        .NUM_VOICES(NUM_VOICES),
        .AGE_W     (AGE_W)
    ) u_select (
        .free     (free),
        .ages     (ages_flat),
        .grant    (grant),
        .none_free(none_free)
    );

    assign accept = load_new_note && (!none_free || (|grant));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                age[i] <= '0;
            end
        end else if (accept) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (grant[i]) begin
                    age[i] <= '0;
                end else if (age[i] != {AGE_W{1'b1}}) begin
                    age[i] <= age[i] + AGE_W'(1);
                end
            end
        end
    end
`else
    voice_select #(
        .NUM_VOICES(NUM_VOICES),
        .AGE_W     (AGE_W)
    ) u_select (
        .free     (free),
        .grant    (grant),
        .none_free(none_free)
    );

    assign accept = load_new_note && !none_free;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            voice_load     <= '0;
            voice_note     <= '0;
            voice_duration <= '0;
            note_dropped   <= 1'b0;
            pending        <= '0;
        end else begin
            voice_load   <= accept ? grant : '0;
            note_dropped <= load_new_note && !accept;
            pending      <= (pending & ~voice_playing) | (accept ? grant : '0);
            if (accept) begin
                voice_note     <= note_to_load;
                voice_duration <= duration_to_load;
            end
        end
    end

    always_comb begin
        active_count = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            active_count = active_count + CNT_W'(voice_playing[i] | pending[i]);
        end
    end

    // Mixer
    mix_state_e                  state;
    logic [NUM_VOICES-1:0]       got;
    logic signed [SAMPLE_W-1:0]  samp [NUM_VOICES];
    logic signed [SUM_W-1:0]     mix_sum;
    logic signed [SUM_W-1:0]     mix_shifted;
    logic [SAMPLE_W-1:0]         mix_sat;

    always_comb begin
        mix_sum = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            mix_sum = mix_sum + SUM_W'(samp[i]);
        end
        mix_shifted = mix_sum >>> MIX_SHIFT;
        mix_sat     = SAMPLE_W'(saturate(32'(mix_shifted), SAMPLE_W));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= COLLECT;
            got              <= '0;
            sample_out       <= '0;
            new_sample_ready <= 1'b0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                samp[i] <= '0;
            end
        end else begin
            new_sample_ready <= 1'b0;
            // Strobes are latched in both states; a repeat just overwrites the sample.
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (voice_sample_ready[i]) begin
                    samp[i] <= voice_sample[i*SAMPLE_W +: SAMPLE_W];
                end
            end
            case (state)
                COLLECT: begin
                    got <= got | voice_sample_ready;
                    if ((got | voice_sample_ready) == {NUM_VOICES{1'b1}}) begin
                        state <= EMIT;
                    end
                end
                EMIT: begin
                    sample_out       <= mix_sat;
                    new_sample_ready <= 1'b1;
                    got              <= voice_sample_ready;
                    state            <= COLLECT;
                end
                default: state <= COLLECT;
            endcase
        end
    end

    assign mix_state = state;

endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator: allocation, drop/steal, mixing, saturation, reset.
module tb_voice_allocator;
    import voice_pkg::*;

    localparam int NV = 3;
    localparam int SW = 16;
    localparam int NW = 6;
    localparam int DW = 6;
    localparam int CW = $clog2(NV + 1);

    logic           clk = 1'b0;
    logic           reset_n;
    logic           load_new_note;
    logic [NW-1:0]  note_to_load;
    logic [DW-1:0]  duration_to_load;
    logic [NV-1:0]  voice_playing;
    logic [NV*SW-1:0] voice_sample;
    logic [NV-1:0]  voice_sample_ready;

    logic [NV-1:0]  voice_load;
    logic [NW-1:0]  voice_note;
    logic [DW-1:0]  voice_duration;
    logic [SW-1:0]  sample_out;
    logic           new_sample_ready;
    logic [CW-1:0]  active_count;
    logic           note_dropped;
    mix_state_e     mix_state;

    logic [NV-1:0]  s0_load;
    logic [NW-1:0]  s0_note;
    logic [DW-1:0]  s0_dur;
    logic [SW-1:0]  s0_out;
    logic           s0_nsr;
    logic [CW-1:0]  s0_active;
    logic           s0_dropped;
    mix_state_e     s0_state;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    voice_allocator #(.NUM_VOICES(NV), .SAMPLE_W(SW), .NOTE_W(NW), .DUR_W(DW),
                      .MIX_SHIFT(2), .AGE_W(8)) dut (
        .clk(clk), .reset_n(reset_n), .load_new_note(load_new_note),
        .note_to_load(note_to_load), .duration_to_load(duration_to_load),
        .voice_playing(voice_playing), .voice_sample(voice_sample),
        .voice_sample_ready(voice_sample_ready), .voice_load(voice_load),
        .voice_note(voice_note), .voice_duration(voice_duration),
        .sample_out(sample_out), .new_sample_ready(new_sample_ready),
        .active_count(active_count), .note_dropped(note_dropped),
        .mix_state(mix_state)
    );

    voice_allocator #(.NUM_VOICES(NV), .SAMPLE_W(SW), .NOTE_W(NW), .DUR_W(DW),
                      .MIX_SHIFT(0), .AGE_W(8)) dut_s0 (
        .clk(clk), .reset_n(reset_n), .load_new_note(load_new_note),
        .note_to_load(note_to_load), .duration_to_load(duration_to_load),
        .voice_playing(voice_playing), .voice_sample(voice_sample),
        .voice_sample_ready(voice_sample_ready), .voice_load(s0_load),
        .voice_note(s0_note), .voice_duration(s0_dur),
        .sample_out(s0_out), .new_sample_ready(s0_nsr),
        .active_count(s0_active), .note_dropped(s0_dropped),
        .mix_state(s0_state)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_sample(input int idx, input logic [SW-1:0] val);
        voice_sample[idx*SW +: SW] = val;
        voice_sample_ready[idx] = 1'b1;
    endtask

    task automatic request(input logic [NW-1:0] n, input logic [DW-1:0] d);
        load_new_note    = 1'b1;
        note_to_load     = n;
        duration_to_load = d;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick();
        tick();
        checks++; if (voice_load !== 3'b000) begin errors++; $display("FAIL reset_voice_load: got %b expected 000", voice_load); end
        checks++; if (sample_out !== 16'h0000 || new_sample_ready !== 1'b0) begin errors++; $display("FAIL reset_mix: got out=%h nsr=%b expected 0000/0", sample_out, new_sample_ready); end
        checks++; if (active_count !== 2'd0 || note_dropped !== 1'b0) begin errors++; $display("FAIL reset_counts: got active=%0d dropped=%b expected 0/0", active_count, note_dropped); end
        checks++; if (mix_state !== COLLECT) begin errors++; $display("FAIL reset_state: got %0d expected COLLECT", mix_state); end
        reset_n = 1'b1;
        tick();
        checks++; if (voice_note !== 6'd0 || voice_duration !== 6'd0) begin errors++; $display("FAIL reset_note: got note=%0d dur=%0d expected 0/0", voice_note, voice_duration); end
    endtask

    task automatic test_allocation();
        request(6'd5, 6'd10);
        tick();
        checks++; if (voice_load !== 3'b001 || voice_note !== 6'd5 || voice_duration !== 6'd10) begin errors++; $display("FAIL alloc_first: got load=%b note=%0d dur=%0d expected 001/5/10", voice_load, voice_note, voice_duration); end
        checks++; if (active_count !== 2'd1) begin errors++; $display("FAIL alloc_active1: got %0d expected 1", active_count); end
        request(6'd17, 6'd20);
        tick();
        checks++; if (voice_load !== 3'b010 || voice_note !== 6'd17 || voice_duration !== 6'd20) begin errors++; $display("FAIL alloc_second: got load=%b note=%0d dur=%0d expected 010/17/20", voice_load, voice_note, voice_duration); end
        request(6'd63, 6'd1);
        tick();
        checks++; if (voice_load !== 3'b100 || voice_note !== 6'd63 || voice_duration !== 6'd1) begin errors++; $display("FAIL alloc_third: got load=%b note=%0d dur=%0d expected 100/63/1", voice_load, voice_note, voice_duration); end
        load_new_note = 1'b0;
        tick();
        checks++; if (voice_load !== 3'b000) begin errors++; $display("FAIL alloc_idle: got %b expected 000", voice_load); end
        checks++; if (active_count !== 2'd3) begin errors++; $display("FAIL alloc_active3: got %0d expected 3", active_count); end
    endtask

    task automatic test_all_busy();
        voice_playing = 3'b111;
        tick();
        request(6'd7, 6'd3);
        tick();
`ifdef VOICE_STEAL_EN
        checks++; if (voice_load !== 3'b001 || note_dropped !== 1'b0 || voice_note !== 6'd7) begin errors++; $display("FAIL steal_oldest: got load=%b dropped=%b note=%0d expected 001/0/7", voice_load, note_dropped, voice_note); end
        request(6'd9, 6'd4);
        tick();
        checks++; if (voice_load !== 3'b010 || note_dropped !== 1'b0 || voice_note !== 6'd9) begin errors++; $display("FAIL steal_next: got load=%b dropped=%b note=%0d expected 010/0/9", voice_load, note_dropped, voice_note); end
`else
        checks++; if (voice_load !== 3'b000 || note_dropped !== 1'b1) begin errors++; $display("FAIL drop_pulse: got load=%b dropped=%b expected 000/1", voice_load, note_dropped); end
        checks++; if (voice_note !== 6'd63 || voice_duration !== 6'd1) begin errors++; $display("FAIL drop_hold: got note=%0d dur=%0d expected 63/1", voice_note, voice_duration); end
`endif
        load_new_note = 1'b0;
        tick();
        checks++; if (voice_load !== 3'b000 || note_dropped !== 1'b0) begin errors++; $display("FAIL busy_quiet: got load=%b dropped=%b expected 000/0", voice_load, note_dropped); end
        checks++; if (active_count !== 2'd3) begin errors++; $display("FAIL busy_active: got %0d expected 3", active_count); end
        voice_playing = 3'b000;
        tick();
        checks++; if (active_count !== 2'd0) begin errors++; $display("FAIL busy_release: got %0d expected 0", active_count); end
    endtask

    task automatic test_saturation();
        set_sample(0, 16'h7FFF); set_sample(1, 16'h7FFF); set_sample(2, 16'h7FFF);
        tick();
        voice_sample_ready = '0;
        checks++; if (s0_nsr !== 1'b0) begin errors++; $display("FAIL sat_early: got nsr=%b expected 0", s0_nsr); end
        tick();
        checks++; if (s0_nsr !== 1'b1 || s0_out !== 16'h7FFF) begin errors++; $display("FAIL sat_pos: got nsr=%b out=%h expected 1/7fff", s0_nsr, s0_out); end
        checks++; if (sample_out !== 16'h5FFF) begin errors++; $display("FAIL sat_pos_shift2: got %h expected 5fff", sample_out); end
        set_sample(0, 16'h8000); set_sample(1, 16'h8000); set_sample(2, 16'h8000);
        tick();
        voice_sample_ready = '0;
        tick();
        checks++; if (s0_nsr !== 1'b1 || s0_out !== 16'h8000) begin errors++; $display("FAIL sat_neg: got nsr=%b out=%h expected 1/8000", s0_nsr, s0_out); end
        checks++; if (sample_out !== 16'hA000) begin errors++; $display("FAIL sat_neg_shift2: got %h expected a000", sample_out); end
    endtask

    task automatic test_staggered_mix();
        int pulses;
        logic [SW-1:0] vals [NV];
        vals[0] = 16'd400; vals[1] = -16'sd200; vals[2] = 16'd100;
        pulses = 0;
        for (int c = 0; c < 5; c++) begin
            voice_sample_ready = '0;
            if (c % 2 == 0) set_sample(c / 2, vals[c / 2]);
            tick();
            if (new_sample_ready === 1'b1) pulses++;
        end
        voice_sample_ready = '0;
        checks++; if (pulses !== 0) begin errors++; $display("FAIL stagger_early: got %0d pulses expected 0", pulses); end
        tick();
        checks++; if (new_sample_ready !== 1'b1 || sample_out !== 16'd75) begin errors++; $display("FAIL stagger_mix: got nsr=%b out=%0d expected 1/75", new_sample_ready, sample_out); end
        tick();
        checks++; if (new_sample_ready !== 1'b0 || sample_out !== 16'd75) begin errors++; $display("FAIL stagger_hold: got nsr=%b out=%0d expected 0/75", new_sample_ready, sample_out); end
    endtask

    task automatic test_back_to_back();
        set_sample(0, 16'd1000); set_sample(1, 16'd2000); set_sample(2, 16'd3000);
        tick();
        checks++; if (mix_state !== EMIT) begin errors++; $display("FAIL b2b_emit_state: got %0d expected EMIT", mix_state); end
        set_sample(0, -16'sd4); set_sample(1, -16'sd8); set_sample(2, -16'sd12);
        tick();
        voice_sample_ready = '0;
        checks++; if (new_sample_ready !== 1'b1 || sample_out !== 16'd1500) begin errors++; $display("FAIL b2b_first: got nsr=%b out=%0d expected 1/1500", new_sample_ready, sample_out); end
        tick();
        checks++; if (new_sample_ready !== 1'b0) begin errors++; $display("FAIL b2b_gap: got nsr=%b expected 0", new_sample_ready); end
        tick();
        checks++; if (new_sample_ready !== 1'b1 || sample_out !== 16'hFFFA) begin errors++; $display("FAIL b2b_second: got nsr=%b out=%h expected 1/fffa", new_sample_ready, sample_out); end
        set_sample(0, 16'd1000);
        tick();
        voice_sample_ready = '0;
        set_sample(0, 16'd8);
        tick();
        voice_sample_ready = '0;
        set_sample(1, 16'd4); set_sample(2, 16'd0);
        tick();
        voice_sample_ready = '0;
        checks++; if (new_sample_ready !== 1'b0) begin errors++; $display("FAIL overwrite_early: got nsr=%b expected 0", new_sample_ready); end
        tick();
        checks++; if (new_sample_ready !== 1'b1 || sample_out !== 16'd3) begin errors++; $display("FAIL overwrite_mix: got nsr=%b out=%0d expected 1/3", new_sample_ready, sample_out); end
    endtask

    task automatic test_reset_mid_op();
        int pulses;
        set_sample(0, 16'd11); set_sample(1, 16'd22);
        request(6'd33, 6'd44);
        tick();
        load_new_note = 1'b0;
        voice_sample_ready = '0;
        checks++; if (voice_load !== 3'b001 || voice_note !== 6'd33) begin errors++; $display("FAIL midrst_setup: got load=%b note=%0d expected 001/33", voice_load, voice_note); end
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (voice_load !== 3'b000 || voice_note !== 6'd0 || voice_duration !== 6'd0) begin errors++; $display("FAIL midrst_load: got load=%b note=%0d dur=%0d expected 000/0/0", voice_load, voice_note, voice_duration); end
        checks++; if (sample_out !== 16'd0 || new_sample_ready !== 1'b0 || active_count !== 2'd0 || note_dropped !== 1'b0) begin errors++; $display("FAIL midrst_outs: got out=%h nsr=%b active=%0d dropped=%b expected 0/0/0/0", sample_out, new_sample_ready, active_count, note_dropped); end
        tick();
        reset_n = 1'b1;
        tick();
        pulses = 0;
        set_sample(2, 16'd100);
        for (int c = 0; c < 4; c++) begin
            tick();
            voice_sample_ready = '0;
            if (new_sample_ready === 1'b1) pulses++;
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL midrst_partial: got %0d pulses expected 0", pulses); end
        set_sample(0, 16'd40); set_sample(1, -16'sd20);
        tick();
        voice_sample_ready = '0;
        tick();
        checks++; if (new_sample_ready !== 1'b1 || sample_out !== 16'd30) begin errors++; $display("FAIL midrst_frame: got nsr=%b out=%0d expected 1/30", new_sample_ready, sample_out); end
    endtask

    initial begin
        reset_n            = 1'b0;
        load_new_note      = 1'b0;
        note_to_load       = '0;
        duration_to_load   = '0;
        voice_playing      = '0;
        voice_sample       = '0;
        voice_sample_ready = '0;
        test_reset();
        test_allocation();
        test_all_busy();
        test_saturation();
        test_staggered_mix();
        test_back_to_back();
        test_reset_mid_op();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
